bp_cfg_load_sequencer: RTL

//  Runtime successor to the static per-config parameter tables: walks every core's config

---
 rtl/bp_cfg_load_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/bp_cfg_load_sequencer.sv
// bp_cfg_load_sequencer: walks every core's config words from a caller lookup onto a valid/ready cfg bus,
// bracketing the load with freeze=1 / freeze=0 writes, in per-core or broadcast mode.
module bp_cfg_load_sequencer #(
    parameter int num_cores_p = 4,
    parameter int num_regs_p = 8,
    parameter int addr_width_p = 16,
    parameter int data_width_p = 64,
    parameter logic [addr_width_p-1:0] reg_base_addr_p = 'h10,
    parameter logic [addr_width_p-1:0] freeze_addr_p = 'h02,
    parameter int timeout_p = 1024,
    localparam int core_w = num_cores_p > 1 ? $clog2(num_cores_p) : 1,
    localparam int reg_w = num_regs_p > 1 ? $clog2(num_regs_p) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    start_i,
    input  logic                    bcast_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [core_w-1:0]       rom_core_o,
    output logic [reg_w-1:0]        rom_reg_o,
    input  logic [data_width_p-1:0] rom_data_i,
    output logic                    cfg_v_o,
    input  logic                    cfg_ready_i,
    output logic [core_w-1:0]       cfg_core_o,
    output logic                    cfg_bcast_o,
    output logic [addr_width_p-1:0] cfg_addr_o,
    output logic [data_width_p-1:0] cfg_data_o
);
    localparam int stall_w = timeout_p > 0 ? $clog2(timeout_p + 1) : 1;

    typedef enum logic [2:0] {IDLE, FREEZE, LOAD, UNFREEZE, DONE, ERROR} state_e;

    state_e state_q, state_d;
    logic [core_w-1:0] core_q, core_d;
    logic [reg_w-1:0] reg_q, reg_d;
    logic [stall_w-1:0] stall_q;
    logic bcast_q, err_q;
    logic accept, xfer, stalling, timeout_hit, last_core, last_reg;

    assign accept = state_q == IDLE && start_i;
    assign xfer = cfg_v_o && cfg_ready_i;
    assign stalling = cfg_v_o && !cfg_ready_i;
    assign timeout_hit = timeout_p != 0 && stalling && stall_q == stall_w'(timeout_p - 1);
    // Broadcast mode walks only core 0, so it is always on its last core.
    assign last_core = bcast_q || core_q == core_w'(num_cores_p - 1);
    assign last_reg = reg_q == reg_w'(num_regs_p - 1);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            core_q <= '0;
            reg_q <= '0;
            stall_q <= '0;
            bcast_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            core_q <= core_d;
            reg_q <= reg_d;
            stall_q <= (timeout_p != 0 && stalling) ? stall_q + stall_w'(1) : '0;
            if (accept) bcast_q <= bcast_i;
            if (accept) err_q <= 1'b0;
            else if (timeout_hit) err_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        core_d = core_q;
        reg_d = reg_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = FREEZE;
                    core_d = '0;
                    reg_d = '0;
                end
            end
            FREEZE: begin
                if (xfer) begin
                    state_d = last_core ? LOAD : FREEZE;
                    core_d = last_core ? '0 : core_q + core_w'(1);
                end
            end
            LOAD: begin
                if (xfer) begin
                    reg_d = last_reg ? '0 : reg_q + reg_w'(1);
                    if (last_reg) begin
                        state_d = last_core ? UNFREEZE : LOAD;
                        core_d = last_core ? '0 : core_q + core_w'(1);
                    end
                end
            end
            UNFREEZE: begin
                if (xfer) begin
                    state_d = last_core ? DONE : UNFREEZE;
                    core_d = last_core ? '0 : core_q + core_w'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort drops valid without the closing freeze=0 writes.
        if (timeout_hit) begin
            state_d = ERROR;
            core_d = '0;
            reg_d = '0;
        end
    end

    assign busy_o = state_q != IDLE;
    assign done_o = state_q == DONE;
    assign err_o = err_q;
    assign cfg_v_o = state_q == FREEZE || state_q == LOAD || state_q == UNFREEZE;
    assign cfg_bcast_o = cfg_v_o && bcast_q;
    assign cfg_core_o = (cfg_v_o && !bcast_q) ? core_q : '0;
    assign cfg_addr_o = state_q == LOAD ? reg_base_addr_p + addr_width_p'(reg_q)
                      : cfg_v_o ? freeze_addr_p : '0;
    // rom_data_i is only looked at in LOAD so an undriven lookup cannot leak onto the bus.
    assign cfg_data_o = state_q == LOAD ? rom_data_i : data_width_p'(state_q == FREEZE);
    assign rom_core_o = core_q;
    assign rom_reg_o = reg_q;
endmodule
